// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states and
// the access-legality rule used when a request is accepted.
package lsu_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Unsigned width codes have no store counterpart, so they are errors for stores.
  function automatic logic access_error(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] off);
    logic err;
    err = 1'b0;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = off[0];
      F3_W:    err = (off != 2'b00);
      F3_BU:   err = we;
      F3_HU:   err = we | off[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// merges store bytes/halfwords into a word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            byte_off,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{byte_off, 3'b000} +: 8];
    half_lane = word[{byte_off[1], 4'b0000} +: 16];

    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'h000000, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'h0000, half_lane};
      default: load_data = word;
    endcase

    merged = word;
    case (funct3)
      F3_B:    merged[{byte_off, 3'b000} +: 8] = store_data[7:0];
      F3_H:    merged[{byte_off[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, sub-word stores done as
// read-modify-write against a word-wide memory with combinational read.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  mem_write_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i
);

  import lsu_pkg::*;

  state_e                state_reg;
  logic [1:0]            byte_off_reg;
  logic [2:0]            funct3_reg;
  logic                  we_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged_word;

  assign req_ready_o = (state_reg == ST_IDLE);

  lsu_align u_align (
    .word       (mem_read_data_i),
    .byte_off   (byte_off_reg),
    .funct3     (funct3_reg),
    .store_data (wdata_reg),
    .load_data  (load_data),
    .merged     (merged_word)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg        <= ST_IDLE;
      byte_off_reg     <= 2'b00;
      funct3_reg       <= 3'b000;
      we_reg           <= 1'b0;
      wdata_reg        <= '0;
      resp_valid_o     <= 1'b0;
      resp_err_o       <= 1'b0;
      resp_rdata_o     <= '0;
      mem_write_en_o   <= 1'b0;
      mem_write_data_o <= '0;
      mem_addr_o       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid_i) begin
            byte_off_reg <= req_addr_i[1:0];
            funct3_reg   <= req_funct3_i;
            we_reg       <= req_we_i;
            wdata_reg    <= req_wdata_i;
            mem_addr_o   <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
            if (access_error(req_we_i, req_funct3_i, req_addr_i[1:0])) begin
              state_reg    <= ST_RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_rdata_o <= '0;
            end else if (!req_we_i) begin
              state_reg <= ST_LOAD;
            end else if (req_funct3_i == F3_W) begin
              // Full-word stores skip the read; data goes straight to the write.
              state_reg        <= ST_WRITE;
              mem_write_en_o   <= 1'b1;
              mem_write_data_o <= req_wdata_i;
            end else begin
              state_reg <= ST_RMW_READ;
            end
          end
        end
        ST_LOAD: begin
          resp_rdata_o <= we_reg ? '0 : load_data;
          resp_valid_o <= 1'b1;
          state_reg    <= ST_RESP;
        end
        ST_RMW_READ: begin
          mem_write_data_o <= merged_word;
          mem_write_en_o   <= 1'b1;
          state_reg        <= ST_WRITE;
        end
        ST_WRITE: begin
          mem_write_en_o <= 1'b0;
          resp_rdata_o   <= '0;
          resp_valid_o   <= 1'b1;
          state_reg      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
            state_reg    <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts
// each response, a monitor compares responses and write strobes as they appear.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_we_i         (req_we),
    .req_funct3_i     (req_funct3),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .resp_rdata_o     (resp_rdata),
    .resp_err_o       (resp_err),
    .mem_write_en_o   (mem_write_en),
    .mem_addr_o       (mem_addr),
    .mem_write_data_o (mem_write_data),
    .mem_read_data_i  (mem_read_data)
  );

  // DUT-side memory (1 KiB window, aliased) and the model's byte view of it.
  logic [31:0] dmem [0:255];
  logic [7:0]  bmem [0:1023];
  assign mem_read_data = dmem[mem_addr[9:2]];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          delay;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  bit   mon_on = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout at cycle %0d", name, cycle);
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    return (addr % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    longint v = 0;
    int n = size_of(f3);
    for (int i = 0; i < n; i++) v += longint'(bmem[int'(addr[9:0]) + i]) << (8 * i);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int n = size_of(f3);
    for (int i = 0; i < n; i++) bmem[int'(addr[9:0]) + i] = 8'(wd >> (8 * i));
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    logic [31:0] v = 0;
    for (int i = 0; i < 4; i++) v |= 32'(bmem[int'({addr[9:2], 2'b00}) + i]) << (8 * i);
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input exp_t e);
    int waited = 0;
    forever begin
      @(negedge clk);
      if (q.size() == 0 && req_ready === 1'b1) break;
      waited++;
      if (waited > 100) begin
        timeout("req_ready_wait");
        return;
      end
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    e.acc = cycle;
    q.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic run_model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int delay);
    exp_t e;
    e.rdata = 0; e.err = 0; e.nwr = 0; e.waddr = 0; e.wdata = 0; e.delay = delay; e.acc = 0;
    if (model_err(we, f3, addr)) begin
      e.err = 1; e.lat = 1;
    end else if (!we) begin
      e.rdata = model_load(f3, addr); e.lat = 2;
    end else begin
      model_store(f3, addr, wd);
      e.wdata = model_word(addr);
      e.waddr = {addr[31:2], 2'b00};
      e.nwr = 1;
      e.lat = (f3 == 3'd2) ? 2 : 3;
    end
    issue(we, f3, addr, wd, e);
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic er, input int lat, input int nwr,
                              input logic [31:0] wa, input logic [31:0] wd, input int dly);
    exp_t e;
    e.rdata = rd; e.err = er; e.lat = lat; e.nwr = nwr; e.waddr = wa; e.wdata = wd;
    e.delay = dly; e.acc = 0;
    return e;
  endfunction

  // ---------------- data memory write port (samples on falling edge) ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (mem_write_en === 1'b1) dmem[mem_addr[9:2]] = mem_write_data;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit in_resp = 0;
    int hold = 0;
    int wr_seen = 0;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (q.size() == 0) begin
          chk("idle_write_en", 32'(mem_write_en), 32'd0);
          chk("idle_resp_valid", 32'(resp_valid), 32'd0);
          resp_ready = 1'b0;
        end else begin
          if (mem_write_en === 1'b1) begin
            chk("write_addr", mem_addr, q[0].waddr);
            chk("write_data", mem_write_data, q[0].wdata);
            wr_seen++;
          end
          if (resp_valid === 1'b1) begin
            if (!in_resp) begin
              in_resp = 1;
              hold = q[0].delay;
              chk("latency", 32'(cycle - q[0].acc + 1), 32'(q[0].lat));
            end
            chk("resp_rdata", resp_rdata, q[0].rdata);
            chk("resp_err", 32'(resp_err), 32'(q[0].err));
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (hold == 0) begin
              resp_ready = 1'b1;
              chk("write_count", 32'(wr_seen), 32'(q[0].nwr));
              void'(q.pop_front());
              in_resp = 0;
              wr_seen = 0;
            end else begin
              resp_ready = 1'b0;
              hold--;
            end
          end else begin
            resp_ready = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] legal_f3 [5];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

    rst_ni = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      dmem[i] = $urandom;
      for (int b = 0; b < 4; b++) bmem[4 * i + b] = 8'(dmem[i] >> (8 * b));
    end
    dmem[0] = 32'h8899AABB;
    bmem[0] = 8'hBB; bmem[1] = 8'hAA; bmem[2] = 8'h99; bmem[3] = 8'h88;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_write_en", 32'(mem_write_en), 32'd0);
    chk("rst_write_data", mem_write_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    mon_on = 1;

    // Directed scenarios with hand-computed expectations.
    issue(0, 3'd0, 32'h0001_0001, 32'h0, mk(32'hFFFF_FFAA, 0, 2, 0, 0, 0, 0));
    issue(0, 3'd5, 32'h0001_0002, 32'h0, mk(32'h0000_8899, 0, 2, 0, 0, 0, 1));
    model_store(3'd0, 32'h0001_0003, 32'h5C);
    issue(1, 3'd0, 32'h0001_0003, 32'h5C, mk(32'h0, 0, 3, 1, 32'h0001_0000, 32'h5C99_AABB, 0));
    issue(0, 3'd2, 32'h0001_0002, 32'h0, mk(32'h0, 1, 1, 0, 0, 0, 0));
    model_store(3'd2, 32'h0001_0004, 32'hDEAD_BEEF);
    issue(1, 3'd2, 32'h0001_0004, 32'hDEAD_BEEF, mk(32'h0, 0, 2, 1, 32'h0001_0004, 32'hDEAD_BEEF, 5));
    issue(0, 3'd3, 32'h0001_0000, 32'h0, mk(32'h0, 1, 1, 0, 0, 0, 0));
    issue(1, 3'd4, 32'h0001_0000, 32'h1234, mk(32'h0, 1, 1, 0, 0, 0, 0));
    issue(0, 3'd2, 32'h0001_0004, 32'h0, mk(32'hDEAD_BEEF, 0, 2, 0, 0, 0, 0));

    // Reset pulsed while an SH sits in its read phase: no write, no response.
    begin
      int waited = 0;
      forever begin
        @(negedge clk);
        if (q.size() == 0 && req_ready === 1'b1) break;
        waited++;
        if (waited > 100) begin
          timeout("reset_test_wait");
          break;
        end
      end
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1;
      req_addr = 32'h0001_0006; req_wdata = 32'h0000_7777;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst_ni = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      chk("abort_write_en", 32'(mem_write_en), 32'd0);
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      chk("abort_ready", 32'(req_ready), 32'd1);
      repeat (3) @(negedge clk);
      chk("abort_mem_word", dmem[1], model_word(32'h0001_0004));
    end

    // Randomized traffic against the reference model.
    for (int t = 0; t < 300; t++) begin
      bit          we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          sz;
      we = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = we ? legal_f3[$urandom_range(0, 2)] : legal_f3[$urandom_range(0, 4)];
      sz = size_of(f3);
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = 32'h0001_0000 + 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % sz);
      run_model(we, f3, addr, $urandom, $urandom_range(0, 2));
    end

    begin
      int waited = 0;
      while (q.size() != 0 && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (q.size() != 0) timeout("final_drain");
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32: core and memory word width; only 32 is supported.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  synchronous, active-low reset.
REQ-005 req_valid_i  input  1  core presents a load/store request.
REQ-006 req_ready_o  output  1  unit can accept a request; high only in IDLE.
REQ-007 req_we_i  input  1  1 = store, 0 = load.
REQ-008 req_funct3_i  input  3  RV32I width code: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-009 req_addr_i  input  ADDR_WIDTH  byte address.
REQ-010 req_wdata_i  input  DATA_WIDTH  store data, right-aligned.
REQ-011 resp_valid_o  output  1  response available.
REQ-012 resp_ready_i  input  1  core consumes response.
REQ-013 resp_rdata_o  output  DATA_WIDTH  extended load data; 0 for stores and errors.
REQ-014 resp_err_o  output  1  misaligned access or illegal funct3.
REQ-015 mem_write_en_o  output  1  word write strobe to data memory.
REQ-016 mem_addr_o  output  ADDR_WIDTH  word-aligned address: {addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-017 mem_write_data_o  output  DATA_WIDTH  full word to write, little-endian.
REQ-018 mem_read_data_i  input  DATA_WIDTH  combinational word read of mem_addr_o.

Function
REQ-019 FSM states: IDLE, LOAD, RMW_READ, WRITE, RESP.
REQ-020 Request accepted on the rising edge where req_valid_i && req_ready_o.
- On acceptance, addr, funct3, we and wdata are registered.
REQ-021 Error check on acceptance; error if any of:
- halfword with addr[0]=1;
- word with addr[1:0]!=0;
- funct3 not in REQ-008 (store funct3 limited to 000/001/010).
REQ-022 Transition from IDLE on acceptance:
- error -> RESP with resp_err_o=1, no memory access;
- load -> LOAD;
- SW -> WRITE;
- SB/SH -> RMW_READ.
REQ-023 LOAD (1 cycle):
- drive mem_addr_o;
- select the byte/halfword by addr[1:0], sign- or zero-extend per funct3, register into resp_rdata_o;
- go to RESP.
REQ-024 RMW_READ (1 cycle): register mem_read_data_i with the addressed byte/halfword lanes replaced by req_wdata_i[7:0] or [15:0]; go to WRITE.
REQ-025 WRITE (1 cycle):
- mem_write_en_o=1;
- mem_write_data_o = merged word (sub-word) or req_wdata (SW), stable for the whole cycle, since memory samples on the falling edge;
- go to RESP.
REQ-026 RESP: resp_valid_o=1 and outputs held stable until resp_ready_i=1, then IDLE.
REQ-027 Latency from acceptance edge to resp_valid_o: load 2 cycles, SW 2, SB/SH 3, error 1.
REQ-028 No new request accepted in the RESP cycle; back-to-back throughput is one request per (latency+1) cycles minimum.
REQ-029 mem_write_en_o SHALL be 0 in every state except WRITE.
REQ-030 Address wrap: ADDR_WIDTH bits are passed unmodified except the low two bits; no carry into upper bits.

Reset
REQ-031 While rst_ni=0 at a rising edge, the next state is IDLE. All registered outputs clear to 0: resp_valid_o, resp_err_o, resp_rdata_o, mem_write_en_o, mem_write_data_o, mem_addr_o. req_ready_o is high from the first cycle after reset release.
REQ-032 Reset asserted mid-operation (any state) aborts the transaction. No response is issued. A pending WRITE is suppressed from the reset cycle onward.

Structure
REQ-033 Package lsu_pkg SHALL hold: funct3 width-code constants, the FSM state enum typedef, and the DATA_WIDTH=32 constant.
REQ-034 Sub-module lsu_align (combinational) SHALL implement load extract/extend and store lane merge, instantiated once in load_store_unit.

Verification
REQ-035 Memory word 0x8899AABB at 0x10000; LB addr 0x10001 -> resp_rdata_o=0xFFFFFFAA two cycles after accept.
REQ-036 Same word; LHU addr 0x10002 -> resp_rdata_o=0x00008899, resp_err_o=0.
REQ-037 Memory word 0x8899AABB; SB 0x5C to 0x10003 -> one WRITE cycle with mem_write_data_o=0x5C99AABB, then resp_valid_o at accept+3.
REQ-038 LW addr 0x10002 -> resp_err_o=1 at accept+1, mem_write_en_o never asserted, resp_rdata_o=0.
REQ-039 SW 0xDEADBEEF to 0x10004 with resp_ready_i held low 5 cycles -> resp_valid_o held, req_ready_o=0 throughout, single write only.
REQ-040 Reset pulsed in RMW_READ of an SH -> no write strobe, no response, req_ready_o=1 the cycle after release.
